semi_auto_nav_fsm: RTL and testbench

//  Parametrised semi-automatic driving controller for the car top level.

---
 rtl/semi_auto_nav_fsm_pkg.sv | 51 +++++
 rtl/semi_auto_nav_fsm_if.sv | 30 +++
 rtl/semi_auto_nav_fsm_detector_debounce.sv | 49 ++++
 rtl/semi_auto_nav_fsm.sv | 188 ++++++++++++++++++
 tb/tb_semi_auto_nav_fsm.sv | 297 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/semi_auto_nav_fsm_pkg.sv
// Shared types for the semi-automatic navigation controller: state encoding,
// wall/motor bundles and the Moore output decode.
package semi_auto_nav_fsm_pkg;

  localparam int STATE_W = 3;

  typedef enum logic [STATE_W-1:0] {
    S_FWD    = 3'd0,
    S_WAIT   = 3'd1,
    S_TURN_L = 3'd2,
    S_TURN_R = 3'd3,
    S_UTURN  = 3'd4,
    S_COAST  = 3'd5,
    S_STUCK  = 3'd6
  } nav_state_e;

  // Debounced wall view, 1 = wall present.
  typedef struct packed {
    logic front;
    logic back;
    logic left;
    logic right;
  } walls_t;

  typedef struct packed {
    logic fwd;
    logic left;
    logic right;
    logic stuck;
  } motor_t;

  // Open ahead with walls on both sides: keep driving.
  function automatic logic is_corridor(input walls_t w);
    return !w.front && w.left && w.right;
  endfunction

  // Motor pattern for a state; never more than one motor line high.
  function automatic motor_t motor_decode(input nav_state_e s);
    motor_t m;
    m = 4'b0000;
    case (s)
      S_FWD, S_COAST:   m.fwd   = 1'b1;
      S_TURN_L:         m.left  = 1'b1;
      S_TURN_R, S_UTURN: m.right = 1'b1;
      S_STUCK:          m.stuck = 1'b1;
      default:          m = 4'b0000;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/semi_auto_nav_fsm_if.sv
// Detector, command and motor bundle between the car top level and the
// navigation controller. The controller uses the slave view.
interface semi_auto_nav_fsm_if;

  logic front_detector;
  logic back_detector;
  logic left_detector;
  logic right_detector;
  logic go_straight_command;
  logic turn_left_command;
  logic turn_right_command;
  logic move_forward_signal;
  logic turn_left_signal;
  logic turn_right_signal;
  logic [semi_auto_nav_fsm_pkg::STATE_W-1:0] state;
  logic stuck;

  modport master (
    output front_detector, back_detector, left_detector, right_detector,
    output go_straight_command, turn_left_command, turn_right_command,
    input  move_forward_signal, turn_left_signal, turn_right_signal, state, stuck
  );

  modport slave (
    input  front_detector, back_detector, left_detector, right_detector,
    input  go_straight_command, turn_left_command, turn_right_command,
    output move_forward_signal, turn_left_signal, turn_right_signal, state, stuck
  );

endinterface

// File: rtl/semi_auto_nav_fsm_detector_debounce.sv
// One wall detector: two-flop synchroniser followed by a run-length debouncer.
// The debounced level resets to 1 (wall assumed) and moves only after
// DEBOUNCE_CYCLES consecutive synchronised samples of the opposite level.
module detector_debounce #(
  parameter logic [15:0] DEBOUNCE_CYCLES = 16'd2
) (
  input  logic clk,
  input  logic rst,
  input  logic raw_in,
  output logic deb_out
);

  localparam int CNT_W = $clog2(32'(DEBOUNCE_CYCLES) + 32'd1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 16'd1);

  logic             sync1_r;
  logic             sync2_r;
  logic [CNT_W-1:0] cnt_r;
  logic             deb_r;

  // bring the raw detector into the clock domain
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_r <= 1'b1;
      sync2_r <= 1'b1;
    end else begin
      sync1_r <= raw_in;
      sync2_r <= sync1_r;
    end
  end

  // count disagreeing samples; a single agreeing sample restarts the run
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_r <= {CNT_W{1'b0}};
      deb_r <= 1'b1;
    end else if (sync2_r == deb_r) begin
      cnt_r <= {CNT_W{1'b0}};
    end else if (cnt_r == CNT_LAST) begin
      deb_r <= sync2_r;
      cnt_r <= {CNT_W{1'b0}};
    end else begin
      cnt_r <= cnt_r + CNT_W'(1'b1);
    end
  end

  assign deb_out = deb_r;

endmodule

// File: rtl/semi_auto_nav_fsm.sv
// Semi-automatic driving controller: follows corridors, turns on single exits,
// reverses at dead ends and waits at junctions for one driver command.
module semi_auto_nav_fsm
  import semi_auto_nav_fsm_pkg::*;
#(
  parameter logic [15:0] DEBOUNCE_CYCLES = 16'd2,
  parameter logic [15:0] TURN_CYCLES     = 16'd4,
  parameter logic [15:0] COAST_CYCLES    = 16'd3
) (
  input  logic                 clk,
  input  logic                 rst,
  semi_auto_nav_fsm_if.slave   nav
);

  localparam int TMR_W  = $clog2(32'(TURN_CYCLES) * 32'd2 + 32'(COAST_CYCLES) + 32'd1);
  localparam int INIT_W = $clog2(32'(DEBOUNCE_CYCLES) + 32'd3);

  // Timers load N-1 so the state lasts exactly N clocks before leaving on zero.
  localparam logic [TMR_W-1:0]  TURN_LOAD  = TMR_W'(TURN_CYCLES - 16'd1);
  localparam logic [TMR_W-1:0]  UTURN_LOAD = TMR_W'({TURN_CYCLES[14:0], 1'b0} - 16'd1);
  localparam logic [TMR_W-1:0]  COAST_LOAD = TMR_W'(COAST_CYCLES - 16'd1);
  localparam logic [INIT_W-1:0] INIT_LAST  = INIT_W'(DEBOUNCE_CYCLES + 16'd2);

  logic              det_f_s, det_b_s, det_l_s, det_r_s;
  walls_t            walls_s;
  logic              f_prev_r;
  logic              f_rise_s;
  logic [2:0]        cmd_sync1_r, cmd_sync2_r, cmd_prev_r;  // [2]=straight [1]=left [0]=right
  logic [2:0]        cmd_edge_s;
  logic              cmd_single_s;
  logic [INIT_W-1:0] init_cnt_r;
  logic              init_done_s;
  nav_state_e        state_r, state_nxt_s;
  logic [TMR_W-1:0]  tmr_r, tmr_nxt_s;
  motor_t            motor_r;

  detector_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_front (
    .clk(clk), .rst(rst), .raw_in(nav.front_detector), .deb_out(det_f_s));
  detector_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_back (
    .clk(clk), .rst(rst), .raw_in(nav.back_detector), .deb_out(det_b_s));
  detector_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_left (
    .clk(clk), .rst(rst), .raw_in(nav.left_detector), .deb_out(det_l_s));
  detector_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_right (
    .clk(clk), .rst(rst), .raw_in(nav.right_detector), .deb_out(det_r_s));

  assign walls_s = {det_f_s, det_b_s, det_l_s, det_r_s};

  // synchronise driver commands and keep the previous level for edge detection
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cmd_sync1_r <= 3'b000;
      cmd_sync2_r <= 3'b000;
      cmd_prev_r  <= 3'b000;
    end else begin
      cmd_sync1_r <= {nav.go_straight_command, nav.turn_left_command, nav.turn_right_command};
      cmd_sync2_r <= cmd_sync1_r;
      cmd_prev_r  <= cmd_sync2_r;
    end
  end

  assign cmd_edge_s   = cmd_sync2_r & ~cmd_prev_r;
  // simultaneous commands are ambiguous, so only a lone edge counts
  assign cmd_single_s = (cmd_edge_s != 3'b000) && ((cmd_edge_s & (cmd_edge_s - 3'b001)) == 3'b000);

  // remember the debounced front wall to spot a wall appearing while coasting
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      f_prev_r <= 1'b1;
    end else begin
      f_prev_r <= walls_s.front;
    end
  end

  assign f_rise_s = walls_s.front && !f_prev_r;

  // hold off evaluation until the debouncers have seen real detector data
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      init_cnt_r <= {INIT_W{1'b0}};
    end else if (init_cnt_r != INIT_LAST) begin
      init_cnt_r <= init_cnt_r + INIT_W'(1'b1);
    end else begin
      init_cnt_r <= init_cnt_r;
    end
  end

  assign init_done_s = (init_cnt_r == INIT_LAST);

  // next state and phase timer from the debounced walls and command edges
  always_comb begin
    state_nxt_s = state_r;
    tmr_nxt_s   = tmr_r;
    if (!init_done_s) begin
      state_nxt_s = S_WAIT;
      tmr_nxt_s   = {TMR_W{1'b0}};
    end else begin
      case (state_r)
        S_WAIT: begin
          if (is_corridor(walls_s)) begin
            state_nxt_s = S_FWD;
          end else if (walls_s.front && !walls_s.left && walls_s.right) begin
            state_nxt_s = S_TURN_L;
            tmr_nxt_s   = TURN_LOAD;
          end else if (walls_s.front && walls_s.left && !walls_s.right) begin
            state_nxt_s = S_TURN_R;
            tmr_nxt_s   = TURN_LOAD;
          end else if (walls_s.front && walls_s.left && walls_s.right && !walls_s.back) begin
            state_nxt_s = S_UTURN;
            tmr_nxt_s   = UTURN_LOAD;
          end else if (walls_s.front && walls_s.left && walls_s.right && walls_s.back) begin
            state_nxt_s = S_STUCK;
          end else if (cmd_single_s) begin
            // junction: obey the driver unless the command points into a wall
            if (cmd_edge_s[2] && !walls_s.front) begin
              state_nxt_s = S_COAST;
              tmr_nxt_s   = COAST_LOAD;
            end else if (cmd_edge_s[1] && !walls_s.left) begin
              state_nxt_s = S_TURN_L;
              tmr_nxt_s   = TURN_LOAD;
            end else if (cmd_edge_s[0] && !walls_s.right) begin
              state_nxt_s = S_TURN_R;
              tmr_nxt_s   = TURN_LOAD;
            end else begin
              state_nxt_s = S_WAIT;
            end
          end else begin
            state_nxt_s = S_WAIT;
          end
        end
        S_FWD: begin
          if (is_corridor(walls_s)) begin
            state_nxt_s = S_FWD;
          end else begin
            state_nxt_s = S_WAIT;
          end
        end
        S_TURN_L, S_TURN_R, S_UTURN: begin
          // turns always run to completion, whatever the detectors do
          if (tmr_r == {TMR_W{1'b0}}) begin
            state_nxt_s = S_COAST;
            tmr_nxt_s   = COAST_LOAD;
          end else begin
            tmr_nxt_s   = tmr_r - TMR_W'(1'b1);
          end
        end
        S_COAST: begin
          if (f_rise_s || (tmr_r == {TMR_W{1'b0}})) begin
            state_nxt_s = S_WAIT;
            tmr_nxt_s   = {TMR_W{1'b0}};
          end else begin
            tmr_nxt_s   = tmr_r - TMR_W'(1'b1);
          end
        end
        S_STUCK: begin
          if (walls_s != 4'b1111) begin
            state_nxt_s = S_WAIT;
          end else begin
            state_nxt_s = S_STUCK;
          end
        end
        default: begin
          state_nxt_s = S_WAIT;
          tmr_nxt_s   = {TMR_W{1'b0}};
        end
      endcase
    end
  end

  // state, timer and Moore outputs advance together
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= S_WAIT;
      tmr_r   <= {TMR_W{1'b0}};
      motor_r <= 4'b0000;
    end else begin
      state_r <= state_nxt_s;
      tmr_r   <= tmr_nxt_s;
      motor_r <= motor_decode(state_nxt_s);
    end
  end

  assign nav.move_forward_signal = motor_r.fwd;
  assign nav.turn_left_signal    = motor_r.left;
  assign nav.turn_right_signal   = motor_r.right;
  assign nav.stuck               = motor_r.stuck;
  assign nav.state               = state_r;

endmodule

// File: tb/tb_semi_auto_nav_fsm.sv
// Self-checking bench for semi_auto_nav_fsm: directed scenarios followed by
// random detector/command traffic, all checked against a cycle-level model
// built from sample histories and time-in-state counts.
module tb_semi_auto_nav_fsm;

  localparam int DEB = 2;
  localparam int TRN = 4;
  localparam int CST = 3;
  localparam int OFS = 8;
  localparam int HLEN = 4096;

  localparam int EXP_FWD = 0, EXP_WAIT = 1, EXP_TL = 2, EXP_TR = 3;
  localparam int EXP_UT = 4, EXP_CO = 5, EXP_ST = 6;
  localparam int DF = 0, DB = 1, DL = 2, DR = 3;
  localparam int CG = 0, CL = 1, CR = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  semi_auto_nav_fsm_if nav_bus();

  semi_auto_nav_fsm #(
    .DEBOUNCE_CYCLES(16'(DEB)),
    .TURN_CYCLES(16'(TRN)),
    .COAST_CYCLES(16'(CST))
  ) dut (
    .clk(clk),
    .rst(rst),
    .nav(nav_bus)
  );

  int tests_run;
  int fails;

  bit det_v [4];
  bit cmd_v [3];

  // model: per-edge sample histories, debounced levels, state and time in state
  bit det_h [4][HLEN];
  bit deb_h [4][HLEN];
  bit cmd_h [3][HLEN];
  bit deb_m [4];
  int m_state;
  int m_el;
  int ecnt;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic drive();
    nav_bus.front_detector      = det_v[DF];
    nav_bus.back_detector       = det_v[DB];
    nav_bus.left_detector       = det_v[DL];
    nav_bus.right_detector      = det_v[DR];
    nav_bus.go_straight_command = cmd_v[CG];
    nav_bus.turn_left_command   = cmd_v[CL];
    nav_bus.turn_right_command  = cmd_v[CR];
  endtask

  task automatic set_walls(input bit f, input bit b, input bit l, input bit r);
    det_v[DF] = f; det_v[DB] = b; det_v[DL] = l; det_v[DR] = r;
    drive();
  endtask

  task automatic model_reset();
    ecnt = 0;
    m_state = EXP_WAIT;
    m_el = 0;
    for (int d = 0; d < 4; d++) begin
      deb_m[d] = 1'b1;
      for (int k = 0; k <= OFS; k++) begin
        det_h[d][k] = 1'b1;
        deb_h[d][k] = 1'b1;
      end
    end
    for (int c = 0; c < 3; c++)
      for (int k = 0; k <= OFS; k++) cmd_h[c][k] = 1'b0;
  endtask

  task automatic model_step();
    int i, ne, nxt;
    bit ce [3];
    bit fr, f, b, l, r, flip;
    ecnt++;
    i = ecnt + OFS;
    if (i >= HLEN) begin
      $display("FAIL model_history: edge index %0d exceeds %0d", i, HLEN);
      $fatal(1);
    end
    ne = 0;
    for (int c = 0; c < 3; c++) begin
      ce[c] = cmd_h[c][i-2] && !cmd_h[c][i-3];
      ne += int'(ce[c]);
    end
    fr = deb_h[DF][i-1] && !deb_h[DF][i-2];
    f = deb_m[DF]; b = deb_m[DB]; l = deb_m[DL]; r = deb_m[DR];
    nxt = m_state;
    if (ecnt > DEB + 2) begin
      case (m_state)
        EXP_WAIT: begin
          if (!f && l && r)      nxt = EXP_FWD;
          else if (f && !l && r) nxt = EXP_TL;
          else if (f && l && !r) nxt = EXP_TR;
          else if (f && l && r)  nxt = b ? EXP_ST : EXP_UT;
          else if (ne == 1) begin
            if (ce[CG] && !f)      nxt = EXP_CO;
            else if (ce[CL] && !l) nxt = EXP_TL;
            else if (ce[CR] && !r) nxt = EXP_TR;
          end
        end
        EXP_FWD:        if (!(!f && l && r)) nxt = EXP_WAIT;
        EXP_TL, EXP_TR: if (m_el == TRN) nxt = EXP_CO;
        EXP_UT:         if (m_el == 2 * TRN) nxt = EXP_CO;
        EXP_CO:         if (fr || m_el == CST) nxt = EXP_WAIT;
        EXP_ST:         if (!(f && b && l && r)) nxt = EXP_WAIT;
        default:        nxt = EXP_WAIT;
      endcase
    end
    m_el = (nxt != m_state) ? 1 : m_el + 1;
    m_state = nxt;
    for (int d = 0; d < 4; d++) begin
      det_h[d][i] = det_v[d];
      flip = 1'b1;
      for (int k = i - 1 - DEB; k <= i - 2; k++)
        if (det_h[d][k] == deb_m[d]) flip = 1'b0;
      if (flip) deb_m[d] = !deb_m[d];
      deb_h[d][i] = deb_m[d];
    end
    for (int c = 0; c < 3; c++) cmd_h[c][i] = cmd_v[c];
  endtask

  task automatic check_outputs();
    int motors;
    chk("state", 32'(nav_bus.state), 32'(m_state));
    chk("move_forward", 32'(nav_bus.move_forward_signal), 32'(m_state == EXP_FWD || m_state == EXP_CO));
    chk("turn_left", 32'(nav_bus.turn_left_signal), 32'(m_state == EXP_TL));
    chk("turn_right", 32'(nav_bus.turn_right_signal), 32'(m_state == EXP_TR || m_state == EXP_UT));
    chk("stuck", 32'(nav_bus.stuck), 32'(m_state == EXP_ST));
    motors = int'(nav_bus.move_forward_signal) + int'(nav_bus.turn_left_signal)
           + int'(nav_bus.turn_right_signal);
    chk("motor_exclusive", 32'(motors <= 1), 32'd1);
  endtask

  task automatic tick();
    @(posedge clk);
    if (rst) model_reset();
    else model_step();
    #1;
    check_outputs();
  endtask

  task automatic pulse(input int c);
    cmd_v[c] = 1'b1; drive();
    tick();
    cmd_v[c] = 1'b0; drive();
  endtask

  task automatic run_until(input int target, input int budget, input string tag);
    int n;
    n = 0;
    while (int'(nav_bus.state) != target && n < budget) begin
      tick();
      n++;
    end
    chk(tag, 32'(nav_bus.state), 32'(target));
  endtask

  initial begin
    tests_run = 0;
    fails = 0;
    for (int c = 0; c < 3; c++) cmd_v[c] = 1'b0;
    set_walls(1'b1, 1'b1, 1'b1, 1'b1);
    rst = 1'b1;
    repeat (3) tick();

    // 1: corridor presented under reset, forward after the init window
    set_walls(1'b0, 1'b1, 1'b1, 1'b1);
    tick();
    rst = 1'b0;
    repeat (4) begin
      tick();
      chk("t1_init_wait", 32'(nav_bus.state), 32'(EXP_WAIT));
    end
    tick();
    chk("t1_fwd", 32'(nav_bus.state), 32'(EXP_FWD));
    chk("t1_fwd_sig", 32'(nav_bus.move_forward_signal), 32'd1);

    // 2: right opening, stop, driver turns right
    set_walls(1'b0, 1'b1, 1'b1, 1'b0);
    repeat (4) begin
      tick();
      chk("t2_still_fwd", 32'(nav_bus.state), 32'(EXP_FWD));
    end
    tick();
    chk("t2_wait", 32'(nav_bus.state), 32'(EXP_WAIT));
    chk("t2_fwd_drop", 32'(nav_bus.move_forward_signal), 32'd0);
    pulse(CR);
    repeat (2) tick();
    chk("t2_turn_r", 32'(nav_bus.state), 32'(EXP_TR));
    repeat (3) begin
      tick();
      chk("t2_turn_r_sig", 32'(nav_bus.turn_right_signal), 32'd1);
    end
    repeat (3) begin
      tick();
      chk("t2_coast", 32'(nav_bus.state), 32'(EXP_CO));
    end
    tick();
    chk("t2_back_wait", 32'(nav_bus.state), 32'(EXP_WAIT));

    // 3: open junction, simultaneous commands ignored, straight accepted
    set_walls(1'b0, 1'b1, 1'b0, 1'b0);
    repeat (6) tick();
    cmd_v[CL] = 1'b1; cmd_v[CR] = 1'b1; drive();
    tick();
    cmd_v[CL] = 1'b0; cmd_v[CR] = 1'b0; drive();
    repeat (5) begin
      tick();
      chk("t3_double_ignored", 32'(nav_bus.state), 32'(EXP_WAIT));
    end
    pulse(CG);
    repeat (2) tick();
    chk("t3_straight_coast", 32'(nav_bus.state), 32'(EXP_CO));
    repeat (3) tick();
    chk("t3_coast_done", 32'(nav_bus.state), 32'(EXP_WAIT));

    // 4: straight into a wall is ignored; single right exit turns by itself
    set_walls(1'b1, 1'b1, 1'b0, 1'b0);
    repeat (6) tick();
    pulse(CG);
    repeat (5) tick();
    chk("t4_blocked_straight", 32'(nav_bus.state), 32'(EXP_WAIT));
    set_walls(1'b1, 1'b1, 1'b1, 1'b0);
    run_until(EXP_TR, 8, "t4_auto_turn_r");

    // 5: dead end -> U-turn for 2*TURN clocks; boxed in -> stuck
    set_walls(1'b1, 1'b0, 1'b1, 1'b1);
    run_until(EXP_UT, 30, "t5_uturn");
    repeat (7) begin
      tick();
      chk("t5_uturn_hold", 32'(nav_bus.turn_right_signal), 32'd1);
    end
    tick();
    chk("t5_uturn_coast", 32'(nav_bus.state), 32'(EXP_CO));
    set_walls(1'b1, 1'b1, 1'b1, 1'b1);
    run_until(EXP_ST, 30, "t5_stuck");
    chk("t5_stuck_flag", 32'(nav_bus.stuck), 32'd1);
    set_walls(1'b1, 1'b1, 1'b0, 1'b1);
    run_until(EXP_WAIT, 10, "t5_unstuck");

    // 6: async reset in the middle of a left turn, then a front glitch
    run_until(EXP_TL, 10, "t6_turn_l");
    repeat (2) tick();
    #2;
    rst = 1'b1;
    #1;
    model_reset();
    check_outputs();
    chk("t6_async_left_drop", 32'(nav_bus.turn_left_signal), 32'd0);
    set_walls(1'b0, 1'b1, 1'b1, 1'b1);
    tick();
    rst = 1'b0;
    run_until(EXP_FWD, 10, "t6_fwd");
    set_walls(1'b1, 1'b1, 1'b1, 1'b1);
    tick();
    set_walls(1'b0, 1'b1, 1'b1, 1'b1);
    repeat (8) begin
      tick();
      chk("t6_glitch_fwd", 32'(nav_bus.state), 32'(EXP_FWD));
    end

    // random detector and command traffic against the model
    for (int cyc = 0; cyc < 1500; cyc++) begin
      if ($urandom_range(5, 0) == 0) begin
        int k;
        k = int'($urandom_range(3, 0));
        det_v[k] = !det_v[k];
      end
      for (int c = 0; c < 3; c++) begin
        if (cmd_v[c]) cmd_v[c] = ($urandom_range(1, 0) == 0);
        else          cmd_v[c] = ($urandom_range(11, 0) == 0);
      end
      drive();
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end

endmodule
